// File: rtl/darkspi_master.sv
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One byte per TX handshake; optional chip-select hold chains bytes into one transaction.
module darkspi_master #(
    parameter int DIV = 4
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic       CS_HOLD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       BUSY,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO,
    output logic       SPI_CSN
);

    if (DIV < 1) begin : g_div_check
        $error("darkspi_master: DIV must be >= 1");
    end

    localparam int                 DIV_W    = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SCK_LO,
        S_SCK_HI,
        S_TRAIL
    } state_t;

    state_t           r_state;
    logic [7:0]       r_tx_shift;
    logic [7:0]       r_rx_shift;
    logic             r_hold;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit;
    logic             w_expire;

    assign w_expire = (r_div == '0);
    assign TX_READY = (r_state == S_IDLE);
    assign BUSY     = !TX_READY;

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state    <= S_IDLE;
            r_tx_shift <= 8'h00;
            r_rx_shift <= 8'h00;
            r_hold     <= 1'b0;
            r_div      <= '0;
            r_bit      <= 3'd0;
            SPI_SCK    <= 1'b0;
            SPI_MOSI   <= 1'b0;
            SPI_CSN    <= 1'b1;
            RX_DATA    <= 8'h00;
            RX_VALID   <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (TX_VALID) begin
                        r_tx_shift <= TX_DATA;
                        r_hold     <= CS_HOLD;
                        SPI_CSN    <= 1'b0;
                        SPI_MOSI   <= TX_DATA[7];
                        r_div      <= DIV_LOAD;
                        r_bit      <= 3'd0;
                        r_state    <= S_LEAD;
                    end
                end
                S_LEAD, S_SCK_LO: begin
                    if (w_expire) begin
                        // MISO is captured on the same CLK edge that raises SCK
                        SPI_SCK    <= 1'b1;
                        r_rx_shift <= {r_rx_shift[6:0], SPI_MISO};
                        r_div      <= DIV_LOAD;
                        r_state    <= S_SCK_HI;
                    end else begin
                        r_div <= r_div - DIV_ONE;
                    end
                end
                S_SCK_HI: begin
                    if (w_expire) begin
                        SPI_SCK <= 1'b0;
                        r_div   <= DIV_LOAD;
                        if (r_bit != 3'd7) begin
                            r_bit      <= r_bit + 3'd1;
                            SPI_MOSI   <= r_tx_shift[6];
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            r_state    <= S_SCK_LO;
                        end else begin
                            RX_DATA  <= r_rx_shift;
                            RX_VALID <= 1'b1;
                            // With hold, CSN stays low so the next byte continues the transaction
                            r_state  <= r_hold ? S_IDLE : S_TRAIL;
                        end
                    end else begin
                        r_div <= r_div - DIV_ONE;
                    end
                end
                S_TRAIL: begin
                    if (w_expire) begin
                        SPI_CSN <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div - DIV_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_darkspi_master.sv
// Bench for darkspi_master: three instances (DIV=1,2,4) checked cycle by cycle
// against a timeline model derived from the accept cycle.
module tb_darkspi_master;

    logic       CLK = 1'b0;
    logic       RES;
    logic [7:0] txd;
    logic       hold_in;
    logic [2:0] tv;
    logic [2:0] loop_en;
    logic       mval;

    wire [2:0] sck, mosi, csn, rxv, rdy, bsy, miso;
    wire [7:0] rxd [3];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_rx [3];

    always #5 CLK = ~CLK;

    assign miso = (loop_en & mosi) | (~loop_en & {3{mval}});

    darkspi_master #(.DIV(1)) u_d1 (
        .CLK(CLK), .RES(RES), .TX_DATA(txd), .TX_VALID(tv[0]), .TX_READY(rdy[0]),
        .CS_HOLD(hold_in), .RX_DATA(rxd[0]), .RX_VALID(rxv[0]), .BUSY(bsy[0]),
        .SPI_SCK(sck[0]), .SPI_MOSI(mosi[0]), .SPI_MISO(miso[0]), .SPI_CSN(csn[0])
    );
    darkspi_master #(.DIV(2)) u_d2 (
        .CLK(CLK), .RES(RES), .TX_DATA(txd), .TX_VALID(tv[1]), .TX_READY(rdy[1]),
        .CS_HOLD(hold_in), .RX_DATA(rxd[1]), .RX_VALID(rxv[1]), .BUSY(bsy[1]),
        .SPI_SCK(sck[1]), .SPI_MOSI(mosi[1]), .SPI_MISO(miso[1]), .SPI_CSN(csn[1])
    );
    darkspi_master #(.DIV(4)) u_d4 (
        .CLK(CLK), .RES(RES), .TX_DATA(txd), .TX_VALID(tv[2]), .TX_READY(rdy[2]),
        .CS_HOLD(hold_in), .RX_DATA(rxd[2]), .RX_VALID(rxv[2]), .BUSY(bsy[2]),
        .SPI_SCK(sck[2]), .SPI_MOSI(mosi[2]), .SPI_MISO(miso[2]), .SPI_CSN(csn[2])
    );

    function automatic int divof(input int sel);
        case (sel)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    // {csn, sck, mosi, rx_valid, ready, busy, rx_data}
    function automatic logic [13:0] observe(input int sel);
        return {csn[sel], sck[sel], mosi[sel], rxv[sel], rdy[sel], bsy[sel], rxd[sel]};
    endfunction

    // One byte transfer. mode 0: MISO looped to MOSI, 1: MISO held at mval, 2: random MISO.
    // churn keeps TX_VALID high and scrambles TX_DATA/CS_HOLD after the accept.
    task automatic xfer(input int sel, input logic [7:0] data, input logic hold,
                        input int mode, input logic churn, input string name);
        int          d     = divof(sel);
        int          last  = hold ? 16 * d : 17 * d;
        int          w     = 0;
        int          rises = 0;
        int          m;
        logic        prev_sck = 1'b0;
        logic [7:0]  acc = 8'h00;
        logic [7:0]  exp_rx;
        logic [13:0] got, exp;
        logic        e_csn, e_sck, e_mosi, e_rxv, e_rdy;
        loop_en[sel] = (mode == 0);
        while (rdy[sel] !== 1'b1) begin
            @(negedge CLK);
            w++;
            if (w > 200) begin
                checks++; errors++;
                $display("FAIL %s ready_timeout got=%b required=1", name, rdy[sel]);
                return;
            end
        end
        txd = data; hold_in = hold; tv[sel] = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= last + 1; n++) begin
            @(negedge CLK);
            m = n - 1;
            if (!churn || m >= last - 1) tv[sel] = 1'b0;
            if (churn) begin
                txd = 8'($urandom);
                hold_in = 1'($urandom);
            end
            exp_rx = (mode == 0) ? data : (mode == 1) ? {8{mval}} : acc;
            e_csn  = (!hold && m >= 17 * d);
            e_sck  = (m >= d) && (m < 16 * d) && (((m / d) % 2) == 1);
            e_mosi = (m < 16 * d) ? data[7 - m / (2 * d)] : data[0];
            e_rxv  = (m == 16 * d);
            e_rdy  = hold ? (m >= 16 * d) : (m >= 17 * d);
            exp = {e_csn, e_sck, e_mosi, e_rxv, e_rdy, !e_rdy,
                   (m >= 16 * d) ? exp_rx : last_rx[sel]};
            got = observe(sel);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cyc t0+%0d got=%h required=%h", name, n, got, exp);
            end
            if (sck[sel] === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = sck[sel];
            if (mode == 2) begin
                mval = 1'($urandom);
                if (((m + 1) % d == 0) && (((m + 1) / d) % 2 == 1) && (m + 1 < 16 * d))
                    acc = {acc[6:0], mval};
            end
        end
        checks++;
        if (rises !== 8) begin
            errors++;
            $display("FAIL %s sck_rises got=%0d required=8", name, rises);
        end
        last_rx[sel] = (mode == 0) ? data : (mode == 1) ? {8{mval}} : acc;
    endtask

    task automatic check_idle_all(input string name);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (observe(s) !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL %s inst%0d got=%h required=%h", name, s, observe(s),
                         {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
            end
        end
    endtask

    task automatic test_reset();
        RES = 1'b1; tv = 3'b000; txd = 8'h00; hold_in = 1'b0; loop_en = 3'b000; mval = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_idle_all("reset_held");
        RES = 1'b0;
        @(negedge CLK);
        check_idle_all("after_reset");
        for (int s = 0; s < 3; s++) last_rx[s] = 8'h00;
    endtask

    task automatic test_loopback();
        xfer(1, 8'hA5, 1'b0, 0, 1'b0, "loop_a5_div2");
        xfer(0, 8'h81, 1'b0, 0, 1'b0, "loop_81_div1");
    endtask

    task automatic test_miso_high();
        mval = 1'b1;
        xfer(2, 8'h00, 1'b0, 1, 1'b0, "miso1_div4");
    endtask

    task automatic test_back_to_back();
        xfer(1, 8'h3C, 1'b1, 0, 1'b0, "hold_3c");
        xfer(1, 8'hC3, 1'b0, 0, 1'b0, "hold_c3");
    endtask

    task automatic test_valid_churn();
        xfer(1, 8'h96, 1'b0, 0, 1'b1, "churn_div2");
    endtask

    task automatic test_mid_reset();
        logic ok;
        txd = 8'hE7; hold_in = 1'b0; loop_en[1] = 1'b1; tv[1] = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= 9; n++) begin
            @(negedge CLK);
            tv[1] = 1'b0;
        end
        RES = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RES = 1'b0;
        check_idle_all("mid_reset");
        for (int s = 0; s < 3; s++) last_rx[s] = 8'h00;
        ok = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (rxv[1] !== 1'b0 || csn[1] !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_quiet got=%b required=1", ok);
        end
        xfer(1, 8'h5A, 1'b0, 0, 1'b0, "after_reset_5a");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            xfer(i % 3, 8'($urandom), 1'($urandom), 2, 1'b0, $sformatf("rand%0d", i));
        end
        for (int s = 0; s < 3; s++)
            xfer(s, 8'($urandom), 1'b0, 0, 1'b0, $sformatf("rand_close%0d", s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_loopback();
        test_miso_high();
        test_back_to_back();
        test_valid_churn();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
